// File: rtl/pipelined_wallace_multiplier.sv
//------------------------------------------------------------------------------
// Module      : pipelined_wallace_multiplier
// Description : Signed/unsigned WIDTH x WIDTH multiplier with a Baugh-Wooley
//               carry-save tree spread over STAGES valid-tagged ranks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module pipelined_wallace_multiplier #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_pw = 2 * WIDTH;

    typedef logic [c_pw-1:0]                row_t;
    typedef logic [WIDTH-1:0][c_pw-1:0]     mat_t;

    // Baugh-Wooley correction: +2^WIDTH + 2^(2*WIDTH-1), applied only in signed mode
    localparam row_t c_bw_fix = (row_t'(1) << WIDTH) | (row_t'(1) << (c_pw - 1));

    function automatic int next_rows(input int r);
        return (r / 3) * 2 + r % 3;
    endfunction

    function automatic int rows_after(input int lv);
        int r;
        r = WIDTH;
        for (int i = 0; i < 64; i++)
            if (i < lv) r = next_rows(r);
        return r;
    endfunction

    function automatic int count_levels();
        int r;
        int l;
        r = WIDTH;
        l = 0;
        for (int i = 0; i < 64; i++)
            if (r > 2) begin
                r = next_rows(r);
                l++;
            end
        return l;
    endfunction

    localparam int c_levels = count_levels();

    // One Wallace level: every full triple of live rows becomes sum + shifted carry
    function automatic mat_t csa_level(input mat_t x, input int n);
        mat_t y;
        row_t a;
        row_t b;
        row_t c;
        int   g;
        y = '0;
        g = n / 3;
        for (int t = 0; t < WIDTH / 3; t++)
            if (t < g) begin
                a = x[3*t];
                b = x[3*t+1];
                c = x[3*t+2];
                y[2*t]   = a ^ b ^ c;
                y[2*t+1] = ((a & b) | (a & c) | (b & c)) << 1;
            end
        for (int k = 0; k < 2; k++)
            if (k < n % 3) y[2*g+k] = x[3*g+k];
        return y;
    endfunction

    function automatic mat_t reduce_range(input mat_t x, input int lo, input int hi);
        mat_t m;
        m = x;
        for (int l = 0; l < 64; l++)
            if (l >= lo && l < hi) m = csa_level(m, rows_after(l));
        return m;
    endfunction

    function automatic row_t final_sum(input mat_t x, input int lo, input int hi,
                                       input logic mode);
        mat_t m;
        m = reduce_range(x, lo, hi);
        return m[0] + m[1] + (mode ? c_bw_fix : '0);
    endfunction

    logic               w_stall;
    logic               r_out_valid;
    row_t               r_product;

    logic               r_cap_valid;
    logic               r_cap_mode;
    logic [WIDTH-1:0]   r_cap_a;
    logic [WIDTH-1:0]   r_cap_b;
    mat_t               w_pp;

    assign w_stall   = r_out_valid & ~out_ready;
    assign in_ready  = ~w_stall & ~rst;
    assign out_valid = r_out_valid;
    assign product   = r_product;

    // Operand capture so that latency counts from the accepting edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_valid <= 1'b0;
        end else if (!w_stall) begin
            r_cap_valid <= in_valid;
            if (in_valid) begin
                r_cap_a    <= multiplicand;
                r_cap_b    <= multiplier;
                r_cap_mode <= signed_mode;
            end
        end
    end

    // Partial products; signed mode inverts the cross terms with exactly one MSB
    always_comb begin
        logic w_bit;
        w_bit = 1'b0;
        w_pp  = '0;
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++) begin
                w_bit = r_cap_a[j] & r_cap_b[i];
                if (r_cap_mode && ((i == WIDTH - 1) != (j == WIDTH - 1))) w_bit = ~w_bit;
                w_pp[i][i+j] = w_bit;
            end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int c_lo = (c_levels * s) / STAGES;
        localparam int c_hi = (c_levels * (s + 1)) / STAGES;

        mat_t w_in;
        logic w_vin;
        logic w_min;

        if (s == 0) begin : g_src_pp
            assign w_in  = w_pp;
            assign w_vin = r_cap_valid;
            assign w_min = r_cap_mode;
        end else begin : g_src_rank
            assign w_in  = g_stage[s-1].g_rank.r_rows;
            assign w_vin = g_stage[s-1].g_rank.r_valid;
            assign w_min = g_stage[s-1].g_rank.r_mode;
        end

        if (s < STAGES - 1) begin : g_rank
            mat_t w_red;
            mat_t r_rows;
            logic r_valid;
            logic r_mode;

            assign w_red = reduce_range(w_in, c_lo, c_hi);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                end else if (!w_stall) begin
                    r_valid <= w_vin;
                    if (w_vin) begin
                        r_rows <= w_red;
                        r_mode <= w_min;
                    end
                end
            end
        end else begin : g_last
            row_t w_sum;

            assign w_sum = final_sum(w_in, c_lo, c_hi, w_min);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                    r_product   <= '0;
                end else if (!w_stall) begin
                    r_out_valid <= w_vin;
                    if (w_vin) r_product <= w_sum;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/pipelined_wallace_multiplier.md
PIPELINED_WALLACE_MULTIPLIER -- requirements
Module: pipelined_wallace_multiplier

Interface
REQ-001 The parameter WIDTH SHALL default to 8 and set the operand width; legal values are 4..32.
REQ-002 The parameter STAGES SHALL default to 3 and set the pipeline latency in cycles; legal values are 1..4.
REQ-003 The port clk SHALL be an input, 1 bit wide, and be the single clock; all state updates on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, and be the reset: synchronous, active-high.
REQ-005 The port in_valid SHALL be an input, 1 bit wide, and mean the operand set is valid.
REQ-006 The port in_ready SHALL be an output, 1 bit wide, and mean the block accepts an operand set this cycle.
REQ-007 The port multiplicand SHALL be an input, WIDTH bits wide, and carry operand A.
REQ-008 The port multiplier SHALL be an input, WIDTH bits wide, and carry operand B.
REQ-009 The port signed_mode SHALL be an input, 1 bit wide: 1 means two's-complement operands, 0 means unsigned; it is sampled per transaction.
REQ-010 The port out_valid SHALL be an output, 1 bit wide, and mean product is valid.
REQ-011 The port out_ready SHALL be an input, 1 bit wide, and mean the downstream accepts product.
REQ-012 The port product SHALL be an output, 2*WIDTH bits wide, and carry the full-precision result; there is no extra MSB.

Function
REQ-013 A transaction SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-014 Partial products SHALL be reduced by a carry-save (Wallace) tree of full/half adders to two rows, then summed by one final carry-propagate adder.
REQ-015 In signed_mode=1, the partial-product matrix SHALL use Baugh-Wooley sign handling, with the result equal to signed(A)*signed(B) mod 2^(2*WIDTH).
REQ-016 In signed_mode=0, the result SHALL equal unsigned(A)*unsigned(B).
REQ-017 signed_mode SHALL be registered alongside the data through every stage, so that mixed-mode back-to-back transactions are each computed in their own mode.
REQ-018 The pipeline SHALL hold exactly STAGES register ranks, each with a valid bit; the last rank drives product and out_valid directly from flops.
REQ-019 Reduction levels SHALL be distributed across the ranks; the final carry-propagate adder is in the last rank.
REQ-020 Latency: a transaction accepted at edge N SHALL present out_valid=1 with its product after edge N+STAGES, provided no stall occurs.
REQ-021 Stall: stall = out_valid & ~out_ready, and while stall=1 every pipeline rank, including its valid bit, SHALL hold its value.
REQ-022 in_ready SHALL equal ~stall & ~rst, and be combinational.
REQ-023 Bubbles (ranks with valid=0) SHALL NOT be collapsed; throughput is one transaction per cycle when out_ready=1.
REQ-024 product and out_valid SHALL remain stable while stall=1; no transaction is dropped, duplicated or reordered.
REQ-025 When out_valid=0, product SHALL hold its last value and be treated as don't-care by consumers.
REQ-026 Simultaneous accept and output handshake on one edge SHALL both take effect, with the pipeline advancing by one rank.
REQ-027 Operands SHALL NOT be required to remain stable after acceptance.

Reset
REQ-028 While rst=1 at a rising edge, all valid bits SHALL clear to 0, product SHALL clear to 0, and out_valid SHALL be 0 after that edge.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight transactions, with no output produced for them.
REQ-030 While rst=1, in_ready SHALL be 0 and in_valid SHALL be ignored.
REQ-031 The first acceptance SHALL be possible on the first edge with rst=0.

Verification
REQ-032 The bench SHALL cover the unsigned extreme case (WIDTH=8, STAGES=3, out_ready=1): A=255, B=255, signed_mode=0, accepted at edge N -> out_valid=1 after edge N+3 with product=16'hFE01.
REQ-033 The bench SHALL cover the signed corners: (-128)*(-128) -> 16'h4000, (-1)*1 -> 16'hFFFF, and 127*(-128) -> 16'hC080, issued back-to-back with alternating signed_mode and unsigned 200*3 -> 16'h0258 interleaved; each result SHALL come out in order, one per cycle.
REQ-034 The bench SHALL cover backpressure: issue 4 transactions back-to-back, hold out_ready=0 for 2 cycles once the first is out -> in_ready=0 and product stable during the stall; all 4 results emerge in order with none lost.
REQ-035 The bench SHALL cover reset mid-flight: accept 2 transactions, assert rst for 1 cycle before either emerges -> out_valid stays 0 and no result appears; a new 5*6 then yields 16'h001E with latency 3.
REQ-036 The bench SHALL cover the parameter sweep: WIDTH in {4,8,16} and STAGES in {1,4}, with 10k random operands in both modes checked against a reference product, and latency equal to STAGES.
REQ-037 The bench SHALL cover zero and one: 0*x -> 0 and 1*x -> x (unsigned), with x=8'hA5 giving 16'h00A5.
